// File: rtl/iotdf_pkg.sv
// Shared types and constants for the IoT data-filtering datapath.
//   state_e         : output selector FSM states (IDLE, ACTIVE)
//   FN_*            : function select codes driven on fn_sel
//   FN_BASE_DEFAULT : fn_sel code that maps to function channel 0
package iotdf_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Function select codes understood by the filtering datapath.
  localparam int unsigned FN_MAX      = 1;
  localparam int unsigned FN_MIN      = 2;
  localparam int unsigned FN_AVG      = 3;
  localparam int unsigned FN_THR_HI   = 4;
  localparam int unsigned FN_THR_LO   = 5;
  localparam int unsigned FN_PEAK_MAX = 6;
  localparam int unsigned FN_PEAK_MIN = 7;

  // The engine bank starts at the first threshold function.
  localparam int unsigned FN_BASE_DEFAULT = FN_THR_HI;

endpackage : iotdf_pkg

// File: rtl/fn_ch_sel.sv
// Combinational channel picker: maps the latched function code onto one
// engine channel and returns that channel's strobe and data word.
// Ports:
//   sel_q     in  SELW        latched function code
//   fn_en     in  NUM_FN      per-channel result-ready strobes
//   fn_data   in  NUM_FN*DW   per-channel results, channel k at [k*DW +: DW]
//   sel_en    out 1           strobe of the selected channel (0 if code unmapped)
//   sel_data  out DW          data of the selected channel (0 if code unmapped)
//   multi_hot out 1           more than one fn_en bit is high
module fn_ch_sel #(
  parameter int unsigned NUM_FN  = 4,
  parameter int unsigned DW      = 128,
  parameter int unsigned SELW    = 3,
  parameter int unsigned FN_BASE = 4
) (
  input  logic [SELW-1:0]      sel_q,
  input  logic [NUM_FN-1:0]    fn_en,
  input  logic [NUM_FN*DW-1:0] fn_data,
  output logic                 sel_en,
  output logic [DW-1:0]        sel_data,
  output logic                 multi_hot
);

  // Decode code -> channel; an unmapped code selects nothing.
  always_comb begin
    sel_en   = 1'b0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_FN; k++) begin
      if (32'(sel_q) == FN_BASE + k) begin
        sel_en   = fn_en[k];
        sel_data = fn_data[k*DW +: DW];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(fn_en & (fn_en - NUM_FN'(1)));

endmodule : fn_ch_sel

// File: rtl/iot_out_sel.sv
// Registered output selector: latches a function select at frame start and
// forwards the selected engine's results onto a single valid/iot_out stream,
// with a saturating per-frame output count and sticky error flags.
// Build option: define IOT_OUT_ZERO_EN to force iot_out to 0 whenever
// valid is low; otherwise iot_out holds the last emitted word.
// Ports:
//   clk         in  1          rising-edge clock
//   rst         in  1          synchronous active-low reset
//   fn_sel      in  SELW       function select, sampled on accepted frame_start
//   frame_start in  1          frame begin pulse
//   frame_done  in  1          frame end pulse
//   fn_en       in  NUM_FN     per-channel result strobes
//   fn_data     in  NUM_FN*DW  per-channel results
//   err_clr     in  1          clears sticky errors
//   valid       out 1          output strobe
//   iot_out     out DW         output data
//   out_cnt     out CNTW       words emitted in current/last frame
//   busy        out 1          high while a frame is active
//   sel_err     out 1          sticky: frame_start with out-of-range fn_sel
//   coll_err    out 1          sticky: multiple fn_en bits while active
module iot_out_sel
  import iotdf_pkg::*;
#(
  parameter int unsigned NUM_FN  = 4,
  parameter int unsigned DW      = 128,
  parameter int unsigned SELW    = 3,
  parameter int unsigned FN_BASE = FN_BASE_DEFAULT,
  parameter int unsigned CNTW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SELW-1:0]      fn_sel,
  input  logic                 frame_start,
  input  logic                 frame_done,
  input  logic [NUM_FN-1:0]    fn_en,
  input  logic [NUM_FN*DW-1:0] fn_data,
  input  logic                 err_clr,
  output logic                 valid,
  output logic [DW-1:0]        iot_out,
  output logic [CNTW-1:0]      out_cnt,
  output logic                 busy,
  output logic                 sel_err,
  output logic                 coll_err
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  state_e            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [DW-1:0]     iot_out_q, iot_out_d;
  logic [CNTW-1:0]   out_cnt_q, out_cnt_d;
  logic              busy_q, busy_d;
  logic              sel_err_q, sel_err_d;
  logic              coll_err_q, coll_err_d;

  logic              sel_en;
  logic [DW-1:0]     sel_data;
  logic              multi_hot;
  logic              sel_ok_c;
  logic              sel_err_set;
  logic              coll_err_set;

  fn_ch_sel #(
    .NUM_FN  (NUM_FN),
    .DW      (DW),
    .SELW    (SELW),
    .FN_BASE (FN_BASE)
  ) u_fn_ch_sel (
    .sel_q     (sel_q),
    .fn_en     (fn_en),
    .fn_data   (fn_data),
    .sel_en    (sel_en),
    .sel_data  (sel_data),
    .multi_hot (multi_hot)
  );

  // Incoming code maps onto an existing channel.
  assign sel_ok_c = (32'(fn_sel) >= FN_BASE) &&
                    (32'(fn_sel) <= FN_BASE + NUM_FN - 1);

  // State register and output flops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      iot_out_q  <= '0;
      out_cnt_q  <= '0;
      busy_q     <= 1'b0;
      sel_err_q  <= 1'b0;
      coll_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      iot_out_q  <= iot_out_d;
      out_cnt_q  <= out_cnt_d;
      busy_q     <= busy_d;
      sel_err_q  <= sel_err_d;
      coll_err_q <= coll_err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    valid_d      = 1'b0;
`ifdef IOT_OUT_ZERO_EN
    iot_out_d    = '0;
`else
    iot_out_d    = iot_out_q;
`endif
    out_cnt_d    = out_cnt_q;
    sel_err_set  = 1'b0;
    coll_err_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (sel_ok_c) begin
            sel_d     = fn_sel;
            out_cnt_d = '0;
            state_d   = ACTIVE;
          end else begin
            sel_err_set = 1'b1;
          end
        end
      end

      ACTIVE: begin
        // The emission always uses the channel latched before this edge, so
        // a word in flight during a restart still goes out.
        if (sel_en) begin
          valid_d   = 1'b1;
          iot_out_d = sel_data;
          if (out_cnt_q != CNT_MAX) begin
            out_cnt_d = out_cnt_q + CNTW'(1);
          end
        end
        if (multi_hot) begin
          coll_err_set = 1'b1;
        end
        // Restart dominates frame_done; the new frame starts from zero so
        // the in-flight word is not counted.
        if (frame_start) begin
          out_cnt_d = '0;
          if (sel_ok_c) begin
            sel_d = fn_sel;
          end else begin
            sel_err_set = 1'b1;
            state_d     = IDLE;
          end
        end else if (frame_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // A new error in the same cycle beats the clear.
    sel_err_d  = sel_err_set  | (sel_err_q  & ~err_clr);
    coll_err_d = coll_err_set | (coll_err_q & ~err_clr);
    busy_d     = (state_d == ACTIVE);
  end

  assign valid    = valid_q;
  assign iot_out  = iot_out_q;
  assign out_cnt  = out_cnt_q;
  assign busy     = busy_q;
  assign sel_err  = sel_err_q;
  assign coll_err = coll_err_q;

endmodule : iot_out_sel

// File: tb/tb_iot_out_sel.sv
// Self-checking bench for iot_out_sel: directed scenarios followed by random
// traffic, all compared against a frame-level reference model.
// Honours IOT_OUT_ZERO_EN the same way the design does.
module tb_iot_out_sel;

  localparam int unsigned NUM_FN  = 4;
  localparam int unsigned DW      = 128;
  localparam int unsigned SELW    = 3;
  localparam int unsigned FN_BASE = 4;
  localparam int unsigned CNTW    = 8;
  localparam int          CNT_SAT = (1 << CNTW) - 1;
`ifdef IOT_OUT_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst;
  logic [SELW-1:0]      fn_sel;
  logic                 frame_start;
  logic                 frame_done;
  logic [NUM_FN-1:0]    fn_en;
  logic [NUM_FN*DW-1:0] fn_data;
  logic                 err_clr;
  logic                 valid;
  logic [DW-1:0]        iot_out;
  logic [CNTW-1:0]      out_cnt;
  logic                 busy;
  logic                 sel_err;
  logic                 coll_err;

  iot_out_sel #(
    .NUM_FN  (NUM_FN),
    .DW      (DW),
    .SELW    (SELW),
    .FN_BASE (FN_BASE),
    .CNTW    (CNTW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fn_sel      (fn_sel),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .fn_en       (fn_en),
    .fn_data     (fn_data),
    .err_clr     (err_clr),
    .valid       (valid),
    .iot_out     (iot_out),
    .out_cnt     (out_cnt),
    .busy        (busy),
    .sel_err     (sel_err),
    .coll_err    (coll_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  task automatic check_val(input string tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: frame open/closed, selected channel, words counted.
  bit            m_active;
  int            m_ch;
  int            m_cnt;
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_sel_err;
  bit            m_coll_err;

  function automatic logic [DW-1:0] word_of(input int k);
    return fn_data[k*DW +: DW];
  endfunction

  function automatic int ones(input logic [NUM_FN-1:0] v);
    int n = 0;
    for (int i = 0; i < int'(NUM_FN); i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic set_word(input int k, input logic [DW-1:0] v);
    fn_data[k*DW +: DW] = v;
  endtask

  // One clock: predict from current inputs, advance, compare every output.
  task automatic tick();
    bit            n_active = m_active;
    int            n_ch     = m_ch;
    int            n_cnt    = m_cnt;
    bit            n_valid  = 1'b0;
    logic [DW-1:0] n_data   = ZERO_EN ? '0 : m_data;
    bit            n_se     = m_sel_err  && !err_clr;
    bit            n_ce     = m_coll_err && !err_clr;
    int            code     = int'(fn_sel);
    bit            code_ok  = (code >= int'(FN_BASE)) &&
                              (code < int'(FN_BASE + NUM_FN));
    if (!rst) begin
      n_active = 1'b0; n_ch = 0; n_cnt = 0; n_valid = 1'b0;
      n_data = '0; n_se = 1'b0; n_ce = 1'b0;
    end else if (m_active) begin
      if (fn_en[m_ch]) begin
        n_valid = 1'b1;
        n_data  = word_of(m_ch);
        n_cnt   = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
      end
      if (ones(fn_en) > 1) n_ce = 1'b1;
      if (frame_start) begin
        n_cnt = 0;
        if (code_ok) n_ch = code - int'(FN_BASE);
        else begin
          n_se = 1'b1;
          n_active = 1'b0;
        end
      end else if (frame_done) begin
        n_active = 1'b0;
      end
    end else if (frame_start) begin
      if (code_ok) begin
        n_ch = code - int'(FN_BASE);
        n_cnt = 0;
        n_active = 1'b1;
      end else begin
        n_se = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_active = n_active; m_ch = n_ch; m_cnt = n_cnt; m_valid = n_valid;
    m_data = n_data; m_sel_err = n_se; m_coll_err = n_ce;
    check_val("valid",    DW'(valid),    DW'(m_valid));
    check_val("iot_out",  iot_out,       m_data);
    check_val("out_cnt",  DW'(out_cnt),  DW'(m_cnt));
    check_val("busy",     DW'(busy),     DW'(m_active));
    check_val("sel_err",  DW'(sel_err),  DW'(m_sel_err));
    check_val("coll_err", DW'(coll_err), DW'(m_coll_err));
  endtask

  task automatic quiet();
    frame_start = 1'b0;
    frame_done  = 1'b0;
    fn_en       = '0;
    err_clr     = 1'b0;
  endtask

  logic [DW-1:0] rnd_word;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_active = 1'b0; m_ch = 0; m_cnt = 0; m_valid = 1'b0;
    m_data = '0; m_sel_err = 1'b0; m_coll_err = 1'b0;
    rst = 1'b0;
    fn_sel = '0;
    fn_data = '0;
    quiet();

    // Reset state.
    tick(); tick();
    check_val("rst_valid",   DW'(valid),   DW'(0));
    check_val("rst_iot_out", iot_out,      DW'(0));
    check_val("rst_cnt",     DW'(out_cnt), DW'(0));
    check_val("rst_busy",    DW'(busy),    DW'(0));
    rst = 1'b1;
    tick();

    // Basic: code 5 selects channel 1, three words.
    fn_sel = 3'd5; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_val("basic_busy", DW'(busy), DW'(1));
    set_word(1, DW'(128'hA5));
    set_word(0, DW'(128'h11));
    fn_en = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("basic_valid", DW'(valid), DW'(1));
      check_val("basic_data",  iot_out,    DW'(128'hA5));
    end
    fn_en = '0; frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check_val("basic_cnt",    DW'(out_cnt), DW'(3));
    check_val("basic_idle",   DW'(busy),    DW'(0));
    check_val("basic_novld",  DW'(valid),   DW'(0));
    check_val("basic_hold",   iot_out,      ZERO_EN ? DW'(0) : DW'(128'hA5));

    // Invalid select, then clear.
    fn_sel = 3'd2; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check_val("inv_sel_err", DW'(sel_err), DW'(1));
    check_val("inv_busy",    DW'(busy),    DW'(0));
    check_val("inv_valid",   DW'(valid),   DW'(0));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("clr_sel_err", DW'(sel_err), DW'(0));

    // Collision on channel 0.
    fn_sel = 3'd4; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    set_word(0, DW'(1)); set_word(1, DW'(2));
    fn_en = 4'b0011;
    tick();
    check_val("coll_data",  iot_out,        DW'(1));
    check_val("coll_valid", DW'(valid),     DW'(1));
    check_val("coll_err",   DW'(coll_err),  DW'(1));

    // frame_done together with the selected strobe.
    fn_en = 4'b0001; frame_done = 1'b1;
    tick();
    check_val("done_valid", DW'(valid),   DW'(1));
    check_val("done_cnt",   DW'(out_cnt), DW'(2));
    check_val("done_busy",  DW'(busy),    DW'(0));
    quiet();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0; fn_en = 4'b0001;
    tick();
    // Restart with done and an in-flight word from the old channel.
    set_word(0, DW'(77)); set_word(1, DW'(88));
    fn_sel = 3'd5; frame_start = 1'b1; frame_done = 1'b1; fn_en = 4'b0001;
    tick();
    quiet();
    check_val("rs_valid", DW'(valid),   DW'(1));
    check_val("rs_data",  iot_out,      DW'(77));
    check_val("rs_cnt",   DW'(out_cnt), DW'(0));
    check_val("rs_busy",  DW'(busy),    DW'(1));

    // Saturation on channel 1.
    fn_en = 4'b0010;
    for (int i = 0; i < 300; i++) tick();
    check_val("sat_cnt", DW'(out_cnt), DW'(CNT_SAT));

    // Reset mid-frame with the strobe still asserted.
    rst = 1'b0;
    tick();
    check_val("mrst_valid", DW'(valid),   DW'(0));
    check_val("mrst_data",  iot_out,      DW'(0));
    check_val("mrst_cnt",   DW'(out_cnt), DW'(0));
    check_val("mrst_busy",  DW'(busy),    DW'(0));
    check_val("mrst_coll",  DW'(coll_err), DW'(0));
    rst = 1'b1;
    tick();
    check_val("post_rst_valid", DW'(valid), DW'(0));
    fn_en = '0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) != 0);
      frame_start = ($urandom_range(0, 11) == 0);
      frame_done  = ($urandom_range(0, 11) == 0);
      err_clr     = ($urandom_range(0, 24) == 0);
      fn_sel      = SELW'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       fn_en = '0;
        1, 2:    fn_en = NUM_FN'(1) << $urandom_range(0, NUM_FN - 1);
        default: fn_en = NUM_FN'($urandom);
      endcase
      for (int k = 0; k < int'(NUM_FN); k++) begin
        rnd_word = {$urandom, $urandom, $urandom, $urandom};
        set_word(k, rnd_word);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_iot_out_sel
